// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, exception code and load op encodings for the MEM stage
package mem_stage_pkg;
  localparam int ES_TO_MS_BUS_WD = 123;
  localparam int MS_TO_WS_BUS_WD = 119;
  localparam logic [4:0] NO_EX = 5'h1f;
  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5
  } ld_op_e;
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects and extends the loaded byte/half/word from a response word
import mem_stage_pkg::*;
module mem_load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  ld_op,
  input  logic [31:0] pass,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{addr, 3'b000} +: 8];
  assign h = addr[1] ? rdata[31:16] : rdata[15:0];
  always_comb
    result = ld_op == LD_LB  ? {{24{b[7]}}, b}  :
             ld_op == LD_LBU ? {24'b0, b}       :
             ld_op == LD_LH  ? {{16{h[15]}}, h} :
             ld_op == LD_LHU ? {16'b0, h}       :
             ld_op == LD_LW  ? rdata            : pass;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EXE and WB with response buffering and flush discard
import mem_stage_pkg::*;
module mem_stage (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       flush,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [4:0]                 MEM_dest,
  output logic [31:0]                MEM_dest_data,
  output logic                       MEM_data_rdy,
  output logic                       ms_inst_mfc0,
  output logic                       ms_ex
);
  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] bus_r;
  logic [31:0]                data_buf;
  logic                       data_buf_valid;
  logic                       discard;
  logic                       wait_data;
  logic [2:0]                 ld_op;
  logic [31:0]                result;
  logic [31:0]                rdata_sel;
  logic [31:0]                aligned;
  logic [31:0]                final_result;
  logic                       data_ok_live;
  logic                       ms_ready_go;
  logic                       ms_leave;
  assign wait_data      = bus_r[122];
  assign ld_op          = bus_r[121:119];
  assign result         = bus_r[63:32];
  assign data_ok_live   = data_sram_data_ok & ~discard;
  assign ms_ready_go    = ~wait_data | data_buf_valid | data_ok_live;
  assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;
  assign ms_leave       = ms_valid & ms_ready_go & ws_allowin;
  assign rdata_sel      = data_buf_valid ? data_buf : data_sram_rdata;
  mem_load_align u_align (
    .rdata  (rdata_sel),
    .addr   (result[1:0]),
    .ld_op  (ld_op),
    .pass   (result),
    .result (aligned)
  );
  assign final_result  = wait_data ? aligned : result;
  assign ms_to_ws_bus  = {bus_r[118:64], final_result, bus_r[31:0]};
  assign MEM_dest      = bus_r[68:64] & {5{ms_valid & bus_r[69]}};
  assign MEM_dest_data = final_result;
  assign MEM_data_rdy  = ~(ms_valid & wait_data) | data_buf_valid | data_ok_live;
  assign ms_inst_mfc0  = ms_valid & bus_r[111];
  assign ms_ex         = ms_valid & ((bus_r[76:72] != NO_EX) | bus_r[71]);
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid       <= 1'b0;
      bus_r          <= {46'b0, NO_EX, 72'b0};
      data_buf       <= 32'b0;
      data_buf_valid <= 1'b0;
      discard        <= 1'b0;
    end else begin
      if (flush) ms_valid <= 1'b0;
      else if (ms_allowin) ms_valid <= es_to_ms_valid;
      if (es_to_ms_valid && ms_allowin) bus_r <= es_to_ms_bus;
      if (flush || ms_leave) data_buf_valid <= 1'b0;
      else if (ms_valid && wait_data && data_ok_live && !ws_allowin) begin
        data_buf_valid <= 1'b1;
        data_buf       <= data_sram_rdata;
      end
      // a killed load whose response is still outstanding leaves one response to swallow
      if (flush && ms_valid && wait_data && !data_buf_valid && !data_ok_live) discard <= 1'b1;
      else if (data_sram_data_ok) discard <= 1'b0;
    end
  end
endmodule
